// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: waits for data-SRAM response, extends loads, hands off to WB
module mem_stage #(
  parameter int TO_MEM_W = 74,
  parameter int TO_WB_W  = 70
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                EX_to_MEM_valid,
  input  logic [TO_MEM_W-1:0] to_MEM_data,
  output logic                MEM_allow_in,
  output logic                MEM_to_WB_valid,
  output logic [TO_WB_W-1:0]  to_WB_data,
  input  logic                WB_allow_in,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  output logic                fwd_valid,
  output logic [4:0]          fwd_dest,
  output logic [31:0]         fwd_data,
  output logic                fwd_blocked
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                mem_valid_q, mem_valid_d;
  logic [TO_MEM_W-1:0] bundle_q, bundle_d;
  logic [31:0]         hold_q, hold_d;

  logic [31:0] pc;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic        gr_we;
  logic        mem_req;
  logic [2:0]  load_op;
  logic [31:0] load_ext;
  logic [31:0] final_result;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        resp_now;
  logic        ready_go;

  assign pc         = bundle_q[73:42];
  assign dest       = bundle_q[41:37];
  assign alu_result = bundle_q[36:5];
  assign gr_we      = bundle_q[4];
  assign mem_req    = bundle_q[3];
  assign load_op    = bundle_q[2:0];

  always_comb begin
    sel_byte = data_sram_rdata[7:0];
    case (alu_result[1:0])
      2'd1:    sel_byte = data_sram_rdata[15:8];
      2'd2:    sel_byte = data_sram_rdata[23:16];
      2'd3:    sel_byte = data_sram_rdata[31:24];
      default: sel_byte = data_sram_rdata[7:0];
    endcase
    sel_half = alu_result[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    case (load_op)
      3'b001:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b010:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_ext = {24'd0, sel_byte};
      3'b110:  load_ext = {16'd0, sel_half};
      default: load_ext = data_sram_rdata;
    endcase
  end

  // A response only counts while an owed request is outstanding.
  assign resp_now = mem_valid_q & (state_q == S_WAIT) & data_sram_data_ok;
  assign ready_go = mem_valid_q & (~mem_req | (state_q == S_HOLD) | resp_now);

  assign MEM_allow_in    = ~mem_valid_q | (ready_go & WB_allow_in);
  assign MEM_to_WB_valid = ready_go;

  always_comb begin
    if (load_op == 3'b111)
      final_result = alu_result;
    else if (resp_now)
      final_result = load_ext;
    else
      final_result = hold_q;
  end

  assign to_WB_data  = {pc, dest, final_result, gr_we};
  assign fwd_valid   = mem_valid_q & gr_we & (dest != 5'd0);
  assign fwd_dest    = dest;
  assign fwd_data    = final_result;
  assign fwd_blocked = fwd_valid & (load_op != 3'b111) & (state_q == S_WAIT) & ~data_sram_data_ok;

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    bundle_d    = bundle_q;
    hold_d      = hold_q;
    if (MEM_allow_in) begin
      mem_valid_d = EX_to_MEM_valid;
      state_d     = S_IDLE;
      if (EX_to_MEM_valid) begin
        bundle_d = to_MEM_data;
        state_d  = to_MEM_data[3] ? S_WAIT : S_IDLE;
      end
    end else if (resp_now) begin
      // WB stalled in the response cycle: park the extended data.
      state_d = S_HOLD;
      hold_d  = load_ext;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      mem_valid_q <= 1'b0;
      bundle_q    <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      bundle_q    <= bundle_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the five-stage CPU. It sits between EX and WB and is the sending side of the MEM→WB valid/allow-in handshake. It accepts an instruction bundle from EX and, for memory instructions, waits for the data-SRAM response to the request EX issued. For loads it extracts and sign- or zero-extends the loaded byte, half or word. It then presents {pc, dest, final_result, gr_we} to WB and exports a forwarding/hazard view to ID.

## Interface
- TO_MEM_W, 74: width of the EX→MEM bundle, {pc[31:0], dest[4:0], alu_result[31:0], gr_we, mem_req, load_op[2:0]}, MSB first.
- TO_WB_W, 70: width of the MEM→WB bundle, {pc[31:0], dest[4:0], final_result[31:0], gr_we}, MSB first.
- clk  in  1  clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- EX_to_MEM_valid  in  1  EX holds a valid instruction for MEM.
- to_MEM_data  in  TO_MEM_W  EX bundle; sampled on acceptance.
- MEM_allow_in  out  1  MEM can accept a new instruction this cycle.
- MEM_to_WB_valid  out  1  MEM presents a completed instruction.
- to_WB_data  out  TO_WB_W  bundle to WB.
- WB_allow_in  in  1  WB accepts this cycle.
- data_sram_data_ok  in  1  single-cycle response pulse for the request issued by EX.
- data_sram_rdata  in  32  load data; valid only with data_ok.
- fwd_valid  out  1  MEM holds a valid instruction with gr_we=1 and dest≠0.
- fwd_dest  out  5  destination register.
- fwd_data  out  32  final_result as currently known.
- fwd_blocked  out  1  fwd_valid, and the instruction is a load whose data has not yet arrived.

## Operation
- mem_req=1 means EX issued a data-SRAM request (load or store) for this instruction. Exactly one data_ok is owed per such instruction.
- load_op encoding:
  - 3'b000: word load.
  - 3'b001: ld.b, sign-extended.
  - 3'b010: ld.h, sign-extended.
  - 3'b101: ld.bu, zero-extended.
  - 3'b110: ld.hu, zero-extended.
  - 3'b111: not a load (store or ALU instruction).
- Byte select is alu_result[1:0]. Halfword select is alu_result[1]. Misaligned halfword or word accesses never reach MEM, so behaviour for them is don't-care.
- final_result is the extended load data when load_op≠111, otherwise alu_result.
- State machine:
  - IDLE: MEM_valid=0 or mem_req=0.
  - WAIT: mem_req=1 and data_ok not yet seen.
  - HOLD: data_ok seen; the extended result is registered and awaits WB_allow_in.
- Transitions:
  - On accept with mem_req=1 → WAIT.
  - WAIT + data_ok + WB_allow_in → leave MEM. The next state is WAIT/IDLE according to the newly accepted instruction, or IDLE if none is accepted.
  - WAIT + data_ok + !WB_allow_in → HOLD.
  - HOLD + WB_allow_in → leave MEM.
- MEM_ready_go = MEM_valid & (!mem_req | state==HOLD | (state==WAIT & data_ok)).
- MEM_allow_in = !MEM_valid | (MEM_ready_go & WB_allow_in).
- MEM_to_WB_valid = MEM_ready_go.
- The bundle register loads when EX_to_MEM_valid & MEM_allow_in. MEM_valid loads EX_to_MEM_valid whenever MEM_allow_in=1.
- data_ok while MEM_valid=0 or in IDLE/HOLD is ignored: no state change, no data capture.
- fwd_data uses data_sram_rdata (extended) combinationally in the data_ok cycle, and the HOLD register in HOLD.

## Timing
- Reset values: MEM_valid=0, state=IDLE, bundle and hold registers 0. Outputs during reset: MEM_allow_in=1, MEM_to_WB_valid=0, to_WB_data=0, fwd_valid=0, fwd_blocked=0.
- Latency for a non-memory instruction: it is accepted at edge N and presented to WB during cycle N..N+1. It leaves at the next edge with WB_allow_in=1.
- Latency for a load: it is presented in the same cycle data_ok arrives. The earliest case is the first cycle after acceptance.
- Back-to-back throughput is one instruction per cycle when each data_ok arrives in the first MEM cycle and WB_allow_in=1.
- If resetn is asserted in WAIT, the pending data_ok that arrives after reset release is dropped, since MEM_valid=0.
- to_WB_data remains stable while MEM_to_WB_valid=1 and WB_allow_in=0.

## Test plan
- ALU passthrough: bundle pc=0x1c000000, dest=5, alu_result=0x12345678, gr_we=1, mem_req=0, load_op=111, WB_allow_in=1 → next cycle MEM_to_WB_valid=1, to_WB_data={0x1c000000,5,0x12345678,1}, fwd_valid=1, fwd_blocked=0.
- Load extension: rdata=0x80FF7F01.
  - ld.b at addr 0x...03 → 0xFFFFFF80.
  - ld.bu at addr 0x...01 → 0x0000007F.
  - ld.h at addr 0x...02 → 0xFFFF80FF.
  - ld.hu at addr 0x...00 → 0x00007F01.
  - ld.w → 0x80FF7F01.
- Delayed data_ok: ld.w accepted, data_ok asserted 3 cycles later → MEM_allow_in=0 and fwd_blocked=1 for 3 cycles, then MEM_to_WB_valid=1 with the loaded data.
- HOLD: data_ok arrives with WB_allow_in=0 for 2 cycles → state HOLD, to_WB_data stable, rdata changes ignored. Data is delivered when WB_allow_in rises.
- Store: mem_req=1, load_op=111, gr_we=0 → waits for data_ok, then passes with final_result=alu_result and fwd_valid=0.
- Reset in WAIT: resetn driven low for 1 cycle mid-load, then data_ok pulses → MEM_to_WB_valid stays 0 and MEM_allow_in=1.
